// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request scheduler.
// Optional result flags are enabled by defining ALU_SCHED_FLAGS_EN.
package alu_pkg;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_RESP = 2'd2;

    // Operands are zero-extended, so sub wraps mod 2^16 and mul cannot overflow.
    function automatic logic [15:0] alu_calc(op_e op, logic [7:0] a, logic [7:0] b);
        logic [15:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = {8'h00, a} + {8'h00, b};
            OP_SUB:  r = {8'h00, a} - {8'h00, b};
            OP_MUL:  r = {8'h00, a} * {8'h00, b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Round-robin arbiter: search begins one past the previous winner.
import alu_pkg::*;

module alu_sched_rr_arb (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        cand      = '0;
        // k = NREQ wraps back onto last_grant, so it is tried last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_grant + ID_W'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Four-requester ALU scheduler with round-robin grant and a single EXEC slot.
// Define ALU_SCHED_FLAGS_EN to add the rsp_flags output (zero, borrow).
import alu_pkg::*;

module alu_scheduler #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [7:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_id,
    output logic [15:0] rsp_data,
`ifdef ALU_SCHED_FLAGS_EN
    output logic [1:0]  rsp_flags,
`endif
    output logic        busy
);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    op_e             op_q, op_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [15:0]     data_q, data_d;
`ifdef ALU_SCHED_FLAGS_EN
    logic [1:0]      flags_q, flags_d;
`endif

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic [7:0]      sel_a, sel_b;
    op_e             sel_op;
    logic            accept;
    logic [15:0]     res;

    alu_sched_rr_arb u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_NOP;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a  = req_a[8*i +: 8];
                sel_b  = req_b[8*i +: 8];
                sel_op = op_e'(req_op[2*i +: 2]);
            end
        end
    end

    assign accept    = (state_q == S_IDLE) && (|req_valid);
    assign req_ready = (state_q == S_IDLE) ? grant : '0;
    assign res       = alu_calc(op_q, a_q, b_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;
        data_d  = data_q;
`ifdef ALU_SCHED_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    cnt_d   = (sel_op == OP_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    data_d  = res;
`ifdef ALU_SCHED_FLAGS_EN
                    flags_d = {(op_q == OP_SUB) && (a_q < b_q), res == 16'h0000};
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            id_q    <= '0;
            last_q  <= ID_W'(NREQ - 1);
            data_q  <= '0;
`ifdef ALU_SCHED_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            data_q  <= data_d;
`ifdef ALU_SCHED_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state_q != S_IDLE);
`ifdef ALU_SCHED_FLAGS_EN
    assign rsp_flags = flags_q;
`endif

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter MUL_LAT, default 3, cycles spent in EXEC for multiply (legal 1..15).
REQ-002 Parameter NREQ, fixed 4, number of requesters; the id width is 2.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port req_valid  in  4  per-requester operation request.
REQ-006 Port req_ready  out  4  per-requester accept, one-hot or zero.
REQ-007 Port req_a  in  32  four packed 8-bit A operands, requester i at bits [8i+7:8i].
REQ-008 Port req_b  in  32  four packed 8-bit B operands, same packing.
REQ-009 Port req_op  in  8  four packed 2-bit opcodes: 00 add, 01 sub, 10 mul, 11 nop.
REQ-010 Port rsp_valid  out  1  result available.
REQ-011 Port rsp_ready  in  1  consumer accepts result.
REQ-012 Port rsp_id  out  2  requester index that owns the result.
REQ-013 Port rsp_data  out  16  result.
REQ-014 Port busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; no other encodings reachable.
REQ-016 IDLE: with any req_valid high, the block SHALL grant one requester, assert its req_ready in that same cycle, latch its a/b/op/id, and enter EXEC.
REQ-017 Transfer on requester i occurs only when req_valid[i] and req_ready[i] are both high; req_ready is zero outside IDLE.
REQ-018 Arbitration is round-robin: search starts at (last_grant+1) mod 4; after reset, last_grant = 3, so requester 0 has highest priority.
REQ-019 EXEC lasts 1 cycle for add, sub and nop, and MUL_LAT cycles for mul, counted by a 4-bit down-counter; it then enters RESP.
REQ-020 Latency: accept in cycle N, rsp_valid high from cycle N+1+L (L = EXEC length).
REQ-021 Add: zero-extended 16-bit sum, with no overflow possible.
REQ-022 Sub: (A − B) mod 2^16 on zero-extended operands, e.g. 3−5 = 0xFFFE.
REQ-023 Mul: 16-bit unsigned product.
REQ-024 Nop: result 0x0000.
REQ-025 RESP: rsp_valid, rsp_id and rsp_data stay high/stable until rsp_ready; on handshake, go to IDLE, with the next grant no earlier than the following cycle.
REQ-026 A requester dropping req_valid while not granted is legal and SHALL NOT be granted; req_valid changes during EXEC/RESP are ignored.
REQ-027 rsp_ready high outside RESP has no effect.

Reset
REQ-028 While rst is low, the block SHALL be in IDLE with: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, counter=0, last_grant=3, rsp_flags=0.
REQ-029 Reset asserted mid-EXEC or mid-RESP aborts the operation immediately; no response is produced for it after release.
REQ-030 The first grant is possible in the first rising edge with rst high.

Configuration
REQ-031 Macro ALU_SCHED_FLAGS_EN defined: adds output rsp_flags [1:0], valid with rsp_data: bit0 = result zero; bit1 = sub borrow (A<B), else 0.
REQ-032 Macro ALU_SCHED_FLAGS_EN undefined: port rsp_flags and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Package alu_pkg holds the opcode enum (ADD, SUB, MUL, NOP), the FSM state typedef and the NREQ/ID width constants.
REQ-034 Round-robin grant logic lives in sub-module alu_sched_rr_arb (inputs: req[3:0], last_grant; output: one-hot grant plus index).

Verification
REQ-035 After reset, req0 add A=0xFF B=0x01, rsp_ready=1 -> req_ready[0] in cycle N; rsp_valid at N+2 with id 0, data 0x0100.
REQ-036 req2 sub A=3 B=5 -> data 0xFFFE; with ALU_SCHED_FLAGS_EN, flags=2'b10.
REQ-037 req1 mul A=0xFF B=0xFF, MUL_LAT=3 -> rsp_valid at N+4, data 0xFE01, busy high N+1..N+4.
REQ-038 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no requester is granted twice in a row while others wait.
REQ-039 Response held with rsp_ready=0 for 5 cycles -> rsp data/id stable, req_ready stays 0; release -> IDLE, then next grant.
REQ-040 rst low during mul EXEC -> all outputs zero; after release, no stale rsp_valid, and requester 0 wins the first grant.
